// File: rtl/parking_gate_fsm.sv
// Direction-decoding FSM for the car gate: turns the debounced outer/inner
// light-barrier bits into entry/exit pulses and tracks a saturating occupancy.
module parking_gate_fsm #(
  parameter int CAPACITY = 15,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic             car_in,
  output logic             car_out,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_AB,
    OUT_A,
    WAIT_CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  state_t           state, state_nxt;
  logic [1:0]       ab;
  logic             entry_evt, exit_evt, seq_err;
  logic             car_in_nxt, car_out_nxt, err_nxt;
  logic [CNT_W-1:0] count_nxt;

  assign ab = {sensor_a, sensor_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      car_in  <= 1'b0;
      car_out <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      car_in  <= car_in_nxt;
      car_out <= car_out_nxt;
      err     <= err_nxt;
    end
  end

  // Sequence tracking: any jump that skips a step is illegal and parks the
  // FSM in WAIT_CLEAR until both beams are clear again.
  always_comb begin
    state_nxt = state;
    entry_evt = 1'b0;
    exit_evt  = 1'b0;
    seq_err   = 1'b0;
    case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_nxt = IN_A;
          2'b01:   state_nxt = OUT_B;
          2'b11: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
          default: state_nxt = IDLE;
        endcase
      end
      IN_A: begin
        case (ab)
          2'b10:   state_nxt = IN_A;
          2'b11:   state_nxt = IN_AB;
          2'b00:   state_nxt = IDLE;
          default: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
        endcase
      end
      IN_AB: begin
        case (ab)
          2'b11:   state_nxt = IN_AB;
          2'b01:   state_nxt = IN_B;
          2'b10:   state_nxt = IN_A;
          default: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
        endcase
      end
      IN_B: begin
        case (ab)
          2'b01:   state_nxt = IN_B;
          2'b00: begin state_nxt = IDLE; entry_evt = 1'b1; end
          2'b11:   state_nxt = IN_AB;
          default: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
        endcase
      end
      OUT_B: begin
        case (ab)
          2'b01:   state_nxt = OUT_B;
          2'b11:   state_nxt = OUT_AB;
          2'b00:   state_nxt = IDLE;
          default: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
        endcase
      end
      OUT_AB: begin
        case (ab)
          2'b11:   state_nxt = OUT_AB;
          2'b10:   state_nxt = OUT_A;
          2'b01:   state_nxt = OUT_B;
          default: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
        endcase
      end
      OUT_A: begin
        case (ab)
          2'b10:   state_nxt = OUT_A;
          2'b00: begin state_nxt = IDLE; exit_evt = 1'b1; end
          2'b11:   state_nxt = OUT_AB;
          default: begin state_nxt = WAIT_CLEAR; seq_err = 1'b1; end
        endcase
      end
      WAIT_CLEAR: begin
        if (ab == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy saturates; a blocked increment/decrement still pulses the event
  // but raises err instead of wrapping.
  always_comb begin
    car_in_nxt  = entry_evt;
    car_out_nxt = exit_evt;
    err_nxt     = seq_err;
    count_nxt   = count;
    if (entry_evt) begin
      if (count < CAP) count_nxt = count + CNT_W'(1);
      else             err_nxt   = 1'b1;
    end else if (exit_evt) begin
      if (count != '0) count_nxt = count - CNT_W'(1);
      else             err_nxt   = 1'b1;
    end
  end

  assign full  = (count == CAP);
  assign empty = (count == '0);

endmodule
